// File: rtl/clkdiv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : clkdiv_pkg                                                      |
// | Purpose  : Shared types and constants for the clock-divider configuration |
// |            scheduler: FSM state encoding, divider configuration record,   |
// |            reset (power-on) divider setting and the range-check helper.   |
// | Contents : state_t     - scheduler FSM state (3-bit explicit encoding)    |
// |            cfg_t       - {div, high} divider configuration                |
// |            CFG_RESET   - divide-by-10, 4 cycles high                      |
// |            cfg_is_valid- range check for a requested configuration        |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package clkdiv_pkg;

  // Fields of cfg_t are held at this width; the scheduler's DIV_W must not
  // exceed it. Narrower requests are zero-extended on capture.
  localparam int CFG_MAX_W = 16;

  localparam int DEFAULT_DIV  = 10;
  localparam int DEFAULT_HIGH = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRANT  = 3'd1,
    ST_CHECK  = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_SETTLE = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  typedef struct packed {
    logic [CFG_MAX_W-1:0] div;
    logic [CFG_MAX_W-1:0] high;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{
    div:  CFG_MAX_W'(DEFAULT_DIV),
    high: CFG_MAX_W'(DEFAULT_HIGH)
  };

  // A divider needs at least two source cycles per period, and both the high
  // and low phases must be at least one cycle long.
  function automatic logic cfg_is_valid(input cfg_t c);
    return (c.div >= CFG_MAX_W'(2)) &&
           (c.high != '0) &&
           (c.high < c.div);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clkdiv_cfg_sched_rr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rr_arb                                                          |
// | Purpose  : Round-robin arbiter. Combinationally selects the first set     |
// |            request at or after the rotating pointer (wrapping mod NREQ);  |
// |            the pointer moves to one past the granted index on upd.        |
// | Ports    : clk10   in  clock                                               |
// |            rst_n   in  synchronous active-low reset (pointer -> 0)        |
// |            req     in  [NREQ] request vector                              |
// |            upd     in  advance pointer past upd_idx this cycle            |
// |            upd_idx in  [IDX_W] index that was granted                     |
// |            any     out at least one request is set                        |
// |            win     out [IDX_W] winning index (valid when any)             |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module rr_arb #(
  parameter int NREQ = 4
) (
  input  logic                      clk10,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic                      upd,
  input  logic [$clog2(NREQ)-1:0]   upd_idx,
  output logic                      any,
  output logic [$clog2(NREQ)-1:0]   win
);

  localparam int IDX_W = $clog2(NREQ);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic             found;

  always_ff @(posedge clk10) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Explicit wrap so non-power-of-two NREQ never leaves the pointer out of range.
  always_comb begin
    ptr_d = ptr_q;
    if (upd) begin
      ptr_d = (upd_idx == IDX_W'(NREQ - 1)) ? '0 : upd_idx + 1'b1;
    end
  end

  // Scan NREQ positions starting at the pointer; the first hit wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(ptr_q) + k) % NREQ]) begin
        found = 1'b1;
        win   = IDX_W'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  assign any = |req;

endmodule
`default_nettype wire

// File: rtl/clkdiv_cfg_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : clkdiv_cfg_sched                                                |
// | Purpose  : Arbitrates divide-ratio / duty reconfiguration requests from   |
// |            NREQ clients and sequences them onto the programmable clock    |
// |            divider: round-robin grant, range check, valid/ready offer,    |
// |            settle window, then a per-request completion pulse.            |
// | Ports    : clk10     in  divided-domain clock                             |
// |            rst_n     in  synchronous active-low reset                     |
// |            req       in  [NREQ] level requests, held until own done       |
// |            req_div   in  [NREQ*DIV_W] requested divide ratios             |
// |            req_high  in  [NREQ*DIV_W] requested high-phase lengths        |
// |            gnt       out [NREQ] one-hot pulse when operands are latched   |
// |            done      out completion pulse                                 |
// |            done_id   out requester index qualified by done                |
// |            done_err  out qualified by done: rejected or timed out         |
// |            cfg_valid out configuration offer to the divider               |
// |            cfg_div   out offered divide ratio                             |
// |            cfg_high  out offered high count                               |
// |            cfg_ready in  divider accepts at its period boundary           |
// |            cur_div   out last accepted divide ratio                       |
// |            cur_high  out last accepted high count                         |
// |            busy      out FSM not idle                                     |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module clkdiv_cfg_sched
  import clkdiv_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int DIV_W       = 8,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      clk10,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DIV_W-1:0]     req_div,
  input  logic [NREQ*DIV_W-1:0]     req_high,
  output logic [NREQ-1:0]           gnt,
  output logic                      done,
  output logic [$clog2(NREQ)-1:0]   done_id,
  output logic                      done_err,
  output logic                      cfg_valid,
  output logic [DIV_W-1:0]          cfg_div,
  output logic [DIV_W-1:0]          cfg_high,
  input  logic                      cfg_ready,
  output logic [DIV_W-1:0]          cur_div,
  output logic [DIV_W-1:0]          cur_high,
  output logic                      busy
);

  localparam int IDX_W   = $clog2(NREQ);
  localparam int CNT_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // ISSUE gives up after TIMEOUT_CYC offer cycles (counter values 0..TIMEOUT_CYC-1).
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  // SETTLE counts 0..SETTLE_CYC-1 as the settle window and leaves on the
  // cycle after, so the divider has SETTLE_CYC full cycles at the new ratio.
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC);

  // ---------------------------------------------------------------------------
  // Per-requester operand views
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] req_div_a  [NREQ];
  logic [DIV_W-1:0] req_high_a [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign req_div_a[gi]  = req_div[gi*DIV_W +: DIV_W];
    assign req_high_a[gi] = req_high[gi*DIV_W +: DIV_W];
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [IDX_W-1:0] win_q,   win_d;    // arbitration result carried into GRANT
  logic [IDX_W-1:0] id_q,    id_d;     // requester being serviced
  cfg_t             op_q,    op_d;     // latched request operands
  cfg_t             cur_q,   cur_d;    // configuration the divider is running
  logic             err_q,   err_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;    // shared by ISSUE timeout and SETTLE

  logic             arb_any;
  logic [IDX_W-1:0] arb_win;
  logic             arb_upd;

  rr_arb #(
    .NREQ (NREQ)
  ) u_rr_arb (
    .clk10   (clk10),
    .rst_n   (rst_n),
    .req     (req),
    .upd     (arb_upd),
    .upd_idx (win_q),
    .any     (arb_any),
    .win     (arb_win)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk10) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      id_q    <= '0;
      op_q    <= CFG_RESET;
      cur_q   <= CFG_RESET;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      id_q    <= id_d;
      op_q    <= op_d;
      cur_q   <= cur_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    id_d    = id_q;
    op_d    = op_q;
    cur_d   = cur_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    arb_upd = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          win_d   = arb_win;
          state_d = ST_GRANT;
        end
      end

      // Operands are captured here, one cycle after arbitration, which is the
      // cycle gnt is visible to the requester.
      ST_GRANT: begin
        id_d      = win_q;
        op_d.div  = CFG_MAX_W'(req_div_a[win_q]);
        op_d.high = CFG_MAX_W'(req_high_a[win_q]);
        arb_upd   = 1'b1;
        state_d   = ST_CHECK;
      end

      ST_CHECK: begin
        cnt_d = '0;
        if (!cfg_is_valid(op_q)) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (op_q == cur_q) begin
          // Already running this configuration: complete without a handshake.
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          err_d   = 1'b0;
          state_d = ST_ISSUE;
        end
      end

      // Transfer is tested before timeout so acceptance in the last allowed
      // cycle still counts.
      ST_ISSUE: begin
        if (cfg_ready) begin
          cur_d   = op_q;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs (decoded from registered state so reset clears them immediately)
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt = '0;
    if (state_q == ST_GRANT) begin
      gnt[win_q] = 1'b1;
    end
    done      = (state_q == ST_DONE);
    done_id   = id_q;
    done_err  = (state_q == ST_DONE) && err_q;
    cfg_valid = (state_q == ST_ISSUE);
    cfg_div   = op_q.div[DIV_W-1:0];
    cfg_high  = op_q.high[DIV_W-1:0];
    cur_div   = cur_q.div[DIV_W-1:0];
    cur_high  = cur_q.high[DIV_W-1:0];
    busy      = (state_q != ST_IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_clkdiv_cfg_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_clkdiv_cfg_sched                                             |
// | Purpose  : Directed self-checking bench for clkdiv_cfg_sched. Inputs are  |
// |            driven just after the falling edge; outputs are sampled on the |
// |            falling edge. Cycle numbers count rising edges after the       |
// |            falling edge on which a request is raised.                     |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_clkdiv_cfg_sched;

  localparam int NREQ  = 4;
  localparam int DIV_W = 8;

  logic                   clk10 = 1'b0;
  logic                   rst_n;
  logic [NREQ-1:0]        req;
  logic [NREQ*DIV_W-1:0]  req_div;
  logic [NREQ*DIV_W-1:0]  req_high;
  logic [NREQ-1:0]        gnt;
  logic                   done;
  logic [1:0]             done_id;
  logic                   done_err;
  logic                   cfg_valid;
  logic [DIV_W-1:0]       cfg_div;
  logic [DIV_W-1:0]       cfg_high;
  logic                   cfg_ready;
  logic [DIV_W-1:0]       cur_div;
  logic [DIV_W-1:0]       cur_high;
  logic                   busy;

  int vectors     = 0;
  int miscompares = 0;

  // Results of the most recent watch() call
  int g_cyc, g_idx, v_cnt, d_cyc, d_id, d_err;
  bit d_seen;

  always #5 clk10 = ~clk10;

  clkdiv_cfg_sched #(
    .NREQ        (NREQ),
    .DIV_W       (DIV_W),
    .SETTLE_CYC  (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk10     (clk10),
    .rst_n     (rst_n),
    .req       (req),
    .req_div   (req_div),
    .req_high  (req_high),
    .gnt       (gnt),
    .done      (done),
    .done_id   (done_id),
    .done_err  (done_err),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .cfg_ready (cfg_ready),
    .cur_div   (cur_div),
    .cur_high  (cur_high),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int idx, input int d, input int h);
    req_div[idx*DIV_W +: DIV_W]  = DIV_W'(d);
    req_high[idx*DIV_W +: DIV_W] = DIV_W'(h);
  endtask

  // Observe up to budget falling edges, stopping at the first done pulse.
  task automatic watch(input int budget);
    g_cyc  = -1;
    g_idx  = -1;
    v_cnt  = 0;
    d_cyc  = -1;
    d_id   = -1;
    d_err  = -1;
    d_seen = 1'b0;
    for (int c = 1; c <= budget && !d_seen; c++) begin
      @(negedge clk10);
      if (gnt != '0 && g_cyc < 0) begin
        g_cyc = c;
        if (!$onehot(gnt)) begin
          g_idx = 99;
        end else begin
          for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) g_idx = i;
          end
        end
      end
      if (cfg_valid) v_cnt++;
      if (done) begin
        d_seen = 1'b1;
        d_cyc  = c;
        d_id   = int'(done_id);
        d_err  = int'(done_err);
      end
    end
  endtask

  // Drop all requests and let the FSM return to IDLE.
  task automatic finish_req();
    req = '0;
    @(negedge clk10);
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    req_div   = '0;
    req_high  = '0;
    cfg_ready = 1'b0;

    // 1: reset state
    repeat (3) @(negedge clk10);
    check("rst_cur_div",   32'(cur_div),   32'd10);
    check("rst_cur_high",  32'(cur_high),  32'd4);
    check("rst_cfg_div",   32'(cfg_div),   32'd10);
    check("rst_cfg_high",  32'(cfg_high),  32'd4);
    check("rst_gnt",       32'(gnt),       32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_done_err",  32'(done_err),  32'd0);
    check("rst_done_id",   32'(done_id),   32'd0);
    check("rst_cfg_valid", 32'(cfg_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    rst_n = 1'b1;
    @(negedge clk10);

    // 2: single valid request, zero-wait ready
    set_cfg(1, 8, 3);
    cfg_ready = 1'b1;
    req = 4'b0010;
    watch(30);
    finish_req();
    check("t2_gnt_cyc",   32'(g_cyc), 32'd1);
    check("t2_gnt_idx",   32'(g_idx), 32'd1);
    check("t2_valid_cnt", 32'(v_cnt), 32'd1);
    check("t2_done_cyc",  32'(d_cyc), 32'd9);
    check("t2_done_id",   32'(d_id),  32'd1);
    check("t2_done_err",  32'(d_err), 32'd0);
    check("t2_cur_div",   32'(cur_div),  32'd8);
    check("t2_cur_high",  32'(cur_high), 32'd3);
    check("t2_busy_idle", 32'(busy),     32'd0);

    // 3: high == div is rejected
    set_cfg(0, 5, 5);
    req = 4'b0001;
    watch(30);
    finish_req();
    check("t3_done_cyc",  32'(d_cyc), 32'd3);
    check("t3_done_id",   32'(d_id),  32'd0);
    check("t3_done_err",  32'(d_err), 32'd1);
    check("t3_valid_cnt", 32'(v_cnt), 32'd0);
    check("t3_cur_div",   32'(cur_div), 32'd8);

    // No-op: same as current config, no handshake
    set_cfg(2, 8, 3);
    req = 4'b0100;
    watch(30);
    finish_req();
    check("noop_done_cyc",  32'(d_cyc), 32'd3);
    check("noop_done_id",   32'(d_id),  32'd2);
    check("noop_done_err",  32'(d_err), 32'd0);
    check("noop_valid_cnt", 32'(v_cnt), 32'd0);

    // div=1 / high=0 rejected (also brings the rr pointer back to 0)
    set_cfg(3, 1, 0);
    req = 4'b1000;
    watch(30);
    finish_req();
    check("div1_done_err", 32'(d_err), 32'd1);
    check("div1_done_id",  32'(d_id),  32'd3);
    check("div1_cur_div",  32'(cur_div), 32'd8);

    // 4: round-robin fairness
    set_cfg(0, 6, 2);
    set_cfg(1, 7, 3);
    set_cfg(2, 9, 4);
    set_cfg(3, 12, 6);
    cfg_ready = 1'b1;
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      watch(30);
      check("rr_all_gnt_idx",  32'(g_idx), 32'(k));
      check("rr_all_done_id",  32'(d_id),  32'(k));
      check("rr_all_done_err", 32'(d_err), 32'd0);
    end
    req = 4'b1001;
    watch(30);
    check("rr_1001_first",  32'(g_idx), 32'd0);
    watch(30);
    check("rr_1001_second", 32'(g_idx), 32'd3);
    finish_req();
    check("rr_cur_div",  32'(cur_div),  32'd12);
    check("rr_cur_high", 32'(cur_high), 32'd6);

    // 5: divider never ready -> timeout
    set_cfg(1, 20, 10);
    cfg_ready = 1'b0;
    req = 4'b0010;
    watch(40);
    finish_req();
    check("to_valid_cnt", 32'(v_cnt), 32'd16);
    check("to_done_cyc",  32'(d_cyc), 32'd19);
    check("to_done_id",   32'(d_id),  32'd1);
    check("to_done_err",  32'(d_err), 32'd1);
    check("to_cur_div",   32'(cur_div),  32'd12);
    check("to_cur_high",  32'(cur_high), 32'd6);

    // Ready in the final offer cycle beats the timeout
    req = 4'b0010;
    repeat (18) @(negedge clk10);
    check("last_valid_on", 32'(cfg_valid), 32'd1);
    cfg_ready = 1'b1;
    watch(20);
    finish_req();
    check("last_done_cyc", 32'(d_cyc), 32'd6);
    check("last_done_err", 32'(d_err), 32'd0);
    check("last_cur_div",  32'(cur_div),  32'd20);
    check("last_cur_high", 32'(cur_high), 32'd10);

    // 6: reset during ISSUE
    set_cfg(2, 30, 7);
    cfg_ready = 1'b0;
    req = 4'b0100;
    repeat (5) @(negedge clk10);
    check("mid_valid_before", 32'(cfg_valid), 32'd1);
    rst_n = 1'b0;
    @(negedge clk10);
    check("mid_valid_after", 32'(cfg_valid), 32'd0);
    check("mid_done",        32'(done),      32'd0);
    check("mid_busy",        32'(busy),      32'd0);
    check("mid_cur_div",     32'(cur_div),   32'd10);
    check("mid_cur_high",    32'(cur_high),  32'd4);
    req = '0;
    @(negedge clk10);
    check("mid_no_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk10);
    cfg_ready = 1'b1;
    req = 4'b0100;
    watch(30);
    finish_req();
    check("post_done_cyc", 32'(d_cyc), 32'd9);
    check("post_done_id",  32'(d_id),  32'd2);
    check("post_done_err", 32'(d_err), 32'd0);
    check("post_cur_div",  32'(cur_div),  32'd30);
    check("post_cur_high", 32'(cur_high), 32'd7);

    // Request dropped right after grant still completes
    set_cfg(3, 9, 1);
    req = 4'b1000;
    @(negedge clk10);
    check("drop_gnt", 32'(gnt), 32'b1000);
    req = '0;
    watch(30);
    @(negedge clk10);
    check("drop_done_cyc", 32'(d_cyc), 32'd8);
    check("drop_done_id",  32'(d_id),  32'd3);
    check("drop_done_err", 32'(d_err), 32'd0);
    check("drop_cur_div",  32'(cur_div), 32'd9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
